// File: rtl/bayes_seq_pkg.sv
// Package: bayes_seq_pkg
// Shared types and constants for the Bayesian inference sequencer.
//   state_e     : sequencer FSM states
//   mode_e      : datapath arithmetic domain (stochastic bitstream or log sum)
//   LFSR_TAPS   : Galois feedback mask of the 16-bit random source
//   max_u()     : unsigned maximum, usable in constant expressions
//   score_w()   : width of a class score (wide enough for the log-domain
//                 sum and for a full stochastic bit count)
package bayes_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    RUN   = 3'd2,
    CMP   = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef enum logic {
    STOCH = 1'b0,
    LOG   = 1'b1
  } mode_e;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned score_w(input int unsigned m, input int unsigned n_bits);
    return max_u(m, $clog2(n_bits + 1));
  endfunction

endpackage : bayes_seq_pkg

// File: rtl/bayes_lfsr.sv
// Module: bayes_lfsr
// 16-bit right-shifting Galois LFSR providing the random comparator word for
// the stochastic-computing datapath.
//   clk_i   in  1  clock
//   rst_ni  in  1  async active-low reset, state returns to SEED
//   load_i  in  1  reload SEED (has priority over en_i)
//   en_i    in  1  advance one step this cycle
//   rnd_o   out M  low M bits of the current state
module bayes_lfsr
  import bayes_seq_pkg::*;
#(
  parameter int unsigned M    = 8,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         en_i,
  output logic [M-1:0] rnd_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // NOTE: combinational blocks give every target a default first so no path
  // leaves a signal unassigned and a latch is never inferred.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (en_i) begin
      // Shift out bit 0; when it was set, fold the tap mask back in.
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order across blocks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rnd_o = lfsr_q[M-1:0];

endmodule : bayes_lfsr

// File: rtl/bayes_inference_seq.sv
// Module: bayes_inference_seq
// Sequences one Bayesian inference over the stochastic/log likelihood array.
// For every hypothesis class it presents the class index, lets the RRAM read
// settle, runs the per-row datapath (a full stochastic bitstream, or a single
// log-domain sample), scores the class from the end-of-chain output and keeps
// the running arg-max. The winner is offered on a valid/ready handshake.
//
// Ports
//   clk_i           in   1        clock
//   rst_ni          in   1        async active-low reset
//   start_i         in   1        start pulse, honoured in IDLE only
//   mode_i          in   1        0 = stochastic, 1 = log domain; latched at start
//   class_o         out  CLS_W    class/column under evaluation
//   stoch_log_o     out  1        latched mode to the datapath
//   inference_o     out  1        datapath enable (SETUP and RUN)
//   rnd_o           out  M        random word for the comparator inputs
//   bit_next_i      in   1        end-of-chain stochastic bit
//   data_next_i     in   M        end-of-chain log-domain sum
//   busy_o          out  1        high from start accept until handshake completes
//   result_valid_o  out  1        result available
//   result_ready_i  in   1        consumer accepts result
//   result_class_o  out  CLS_W    winning class
//   result_score_o  out  SCORE_W  winning score, zero-extended
//
// Timing per class: SETTLE cycles in SETUP, L cycles in RUN (L = N_BITS in
// stochastic mode, 1 in log mode), one CMP cycle. result_valid_o therefore
// rises N_CLASS*(SETTLE+L+1)+1 cycles after the cycle in which start_i was
// accepted. N_CLASS must be at least 2 and SETTLE at least 1.
module bayes_inference_seq
  import bayes_seq_pkg::*;
#(
  parameter  int unsigned M       = 8,
  parameter  int unsigned N_CLASS = 4,
  parameter  int unsigned N_BITS  = 255,
  parameter  int unsigned SETTLE  = 2,
  parameter  logic [15:0] SEED    = 16'hACE1,
  localparam int unsigned CLS_W   = $clog2(N_CLASS),
  localparam int unsigned CNT_W   = $clog2(N_BITS + 1),
  localparam int unsigned SCORE_W = score_w(M, N_BITS)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               mode_i,
  output logic [CLS_W-1:0]   class_o,
  output logic               stoch_log_o,
  output logic               inference_o,
  output logic [M-1:0]       rnd_o,
  input  logic               bit_next_i,
  input  logic [M-1:0]       data_next_i,
  output logic               busy_o,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [CLS_W-1:0]   result_class_o,
  output logic [SCORE_W-1:0] result_score_o
);

  // One timer serves both the settle wait and the bitstream length.
  localparam int unsigned TMR_W = max_u(CNT_W, $clog2(SETTLE + 1));

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q,      state_d;
  mode_e              mode_q,       mode_d;
  logic [CLS_W-1:0]   class_q,      class_d;
  logic [TMR_W-1:0]   timer_q,      timer_d;
  logic [SCORE_W-1:0] cnt_q,        cnt_d;
  logic [SCORE_W-1:0] best_score_q, best_score_d;
  logic [CLS_W-1:0]   best_class_q, best_class_d;

  logic start_accept;
  logic settle_last;
  logic bits_last;
  logic class_last;
  logic lfsr_en;

  assign start_accept = (state_q == IDLE) && start_i;
  assign settle_last  = (timer_q == TMR_W'(SETTLE - 1));
  assign bits_last    = (timer_q == TMR_W'(N_BITS - 1));
  assign class_last   = (class_q == CLS_W'(N_CLASS - 1));

  // The random stream moves only while a stochastic bitstream is running, so
  // every class sees a contiguous, reproducible slice of the sequence.
  assign lfsr_en = (state_q == RUN) && (mode_q == STOCH);

  // ---------------------------------------------------------------------------
  // Random source
  // ---------------------------------------------------------------------------
  bayes_lfsr #(
    .M    (M),
    .SEED (SEED)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (start_accept),
    .en_i   (lfsr_en),
    .rnd_o  (rnd_o)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i)                      state_d = SETUP;
      SETUP:   if (settle_last)                  state_d = RUN;
      RUN:     if (mode_q == LOG || bits_last)   state_d = CMP;
      CMP:     state_d = class_last ? DONE : SETUP;
      // A start request in the handshake cycle is dropped: we land in IDLE
      // and only a later start_i is seen there.
      DONE:    if (result_ready_i)               state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_o         = 1'b0;
    inference_o    = 1'b0;
    result_valid_o = 1'b0;
    unique case (state_q)
      IDLE:    ;
      SETUP,
      RUN:     begin
                 busy_o      = 1'b1;
                 inference_o = 1'b1;
               end
      CMP:     busy_o = 1'b1;
      DONE:    begin
                 busy_o         = 1'b1;
                 result_valid_o = 1'b1;
               end
      default: ;
    endcase
  end

  assign class_o        = class_q;
  assign stoch_log_o    = (mode_q == LOG);
  assign result_class_o = best_class_q;
  assign result_score_o = best_score_q;

  // ---------------------------------------------------------------------------
  // Datapath: mode latch, class index, timer, score and running best
  // ---------------------------------------------------------------------------
  always_comb begin
    mode_d       = mode_q;
    class_d      = class_q;
    timer_d      = timer_q;
    cnt_d        = cnt_q;
    best_score_d = best_score_q;
    best_class_d = best_class_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          mode_d       = mode_e'(mode_i);
          class_d      = '0;
          timer_d      = '0;
          cnt_d        = '0;
          best_score_d = '0;
          best_class_d = '0;
        end
      end

      SETUP: begin
        cnt_d   = '0;
        timer_d = settle_last ? '0 : timer_q + 1'b1;
      end

      RUN: begin
        if (mode_q == LOG) begin
          cnt_d   = SCORE_W'(data_next_i);
          timer_d = '0;
        end else begin
          // cnt cannot wrap: SCORE_W holds N_BITS.
          cnt_d   = cnt_q + SCORE_W'(bit_next_i);
          timer_d = bits_last ? '0 : timer_q + 1'b1;
        end
      end

      CMP: begin
        // Strict compare: on a tie the earlier (lower) class stays the winner.
        if (cnt_q > best_score_q) begin
          best_score_d = cnt_q;
          best_class_d = class_q;
        end
        if (!class_last) begin
          class_d = class_q + 1'b1;
        end
        timer_d = '0;
      end

      DONE: ;

      default: ;
    endcase
  end

  // NOTE: every register here, score and best included, has an explicit async
  // reset value so an aborted sweep can never leak a partial result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q       <= STOCH;
      class_q      <= '0;
      timer_q      <= '0;
      cnt_q        <= '0;
      best_score_q <= '0;
      best_class_q <= '0;
    end else begin
      mode_q       <= mode_d;
      class_q      <= class_d;
      timer_q      <= timer_d;
      cnt_q        <= cnt_d;
      best_score_q <= best_score_d;
      best_class_q <= best_class_d;
    end
  end

endmodule : bayes_inference_seq

// File: tb/tb_bayes_inference_seq.sv
// Testbench: tb_bayes_inference_seq
// Directed sequence of inferences against bayes_inference_seq. The bench plays
// the datapath: each cycle it answers the presented class/random word with
// bit_next_i = (rnd < threshold[class]) and data_next_i = log_sum[class].
// Expected scores, winners, latencies and the cycle-by-cycle random word are
// computed from the sequencing rules with plain loops over a software LFSR.
module tb_bayes_inference_seq;

  localparam int unsigned M       = 8;
  localparam int unsigned N_CLASS = 4;
  localparam int unsigned N_BITS  = 255;
  localparam int unsigned SETTLE  = 2;
  localparam logic [15:0] SEED    = 16'hACE1;
  localparam int unsigned CLS_W   = 2;
  localparam int unsigned SCORE_W = 8;
  localparam int          LIMIT   = 5000;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b1;
  logic               start_i = 1'b0;
  logic               mode_i = 1'b0;
  logic [CLS_W-1:0]   class_o;
  logic               stoch_log_o;
  logic               inference_o;
  logic [M-1:0]       rnd_o;
  logic               bit_next_i = 1'b0;
  logic [M-1:0]       data_next_i = '0;
  logic               busy_o;
  logic               result_valid_o;
  logic               result_ready_i = 1'b0;
  logic [CLS_W-1:0]   result_class_o;
  logic [SCORE_W-1:0] result_score_o;

  bayes_inference_seq #(
    .M       (M),
    .N_CLASS (N_CLASS),
    .N_BITS  (N_BITS),
    .SETTLE  (SETTLE),
    .SEED    (SEED)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .mode_i         (mode_i),
    .class_o        (class_o),
    .stoch_log_o    (stoch_log_o),
    .inference_o    (inference_o),
    .rnd_o          (rnd_o),
    .bit_next_i     (bit_next_i),
    .data_next_i    (data_next_i),
    .busy_o         (busy_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_class_o (result_class_o),
    .result_score_o (result_score_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  int thr  [N_CLASS];   // stochastic probability per class, 0..256 over 256
  int dlog [N_CLASS];   // log-domain sum per class

  logic [7:0] rec_q[$];  // observed rnd_o, one entry per busy cycle before DONE
  logic [7:0] exp_q[$];  // expected rnd_o for the same cycles
  logic [7:0] first_q[$];
  int         exp_cls, exp_score, exp_lat;
  logic [7:0] exp_final;
  int         lat, lat_a, cls_a, score_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] galois(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic stoch_bit(input int c, input logic [7:0] r);
    return int'(r) < thr[c];
  endfunction

  // One clock; inputs and samples move 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
    bit_next_i  = stoch_bit(int'(class_o), rnd_o);
    data_next_i = 8'(dlog[int'(class_o)]);
  endtask

  // Expected result and per-cycle random word of one stochastic sweep.
  task automatic model_stoch();
    logic [15:0] s;
    int sc;
    s = SEED;
    exp_q.delete();
    exp_cls = 0;
    exp_score = 0;
    for (int c = 0; c < int'(N_CLASS); c++) begin
      for (int k = 0; k < int'(SETTLE); k++) exp_q.push_back(s[7:0]);
      sc = 0;
      for (int j = 0; j < int'(N_BITS); j++) begin
        exp_q.push_back(s[7:0]);
        sc += int'(stoch_bit(c, s[7:0]));
        s = galois(s);
      end
      exp_q.push_back(s[7:0]);
      if (sc > exp_score) begin
        exp_score = sc;
        exp_cls = c;
      end
    end
    exp_final = s[7:0];
    exp_lat = N_CLASS * (SETTLE + N_BITS + 1) + 1;
  endtask

  task automatic model_log();
    exp_q.delete();
    exp_cls = 0;
    exp_score = 0;
    for (int c = 0; c < int'(N_CLASS); c++) begin
      for (int k = 0; k < int'(SETTLE) + 2; k++) exp_q.push_back(SEED[7:0]);
      if (dlog[c] > exp_score) begin
        exp_score = dlog[c];
        exp_cls = c;
      end
    end
    exp_final = SEED[7:0];
    exp_lat = N_CLASS * (SETTLE + 1 + 1) + 1;
  endtask

  // Pulse start, scramble mode_i afterwards, wait (bounded) for valid.
  task automatic run(input logic m, output int latency);
    rec_q.delete();
    mode_i  = m;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    mode_i  = ~m;
    latency = 1;
    while (!result_valid_o && latency < LIMIT) begin
      rec_q.push_back(rnd_o);
      step();
      latency++;
    end
  endtask

  task automatic check_result(input string tag, input int latency);
    int mm;
    mm = 0;
    if (rec_q.size() != exp_q.size()) mm = 100000 + rec_q.size();
    else foreach (rec_q[i]) if (rec_q[i] !== exp_q[i]) mm++;
    check({tag, "_latency"}, latency, exp_lat);
    check({tag, "_valid"}, result_valid_o, 1'b1);
    check({tag, "_class"}, result_class_o, exp_cls);
    check({tag, "_score"}, result_score_o, exp_score);
    check({tag, "_rnd_seq_errs"}, mm, 0);
    check({tag, "_rnd_done"}, rnd_o, exp_final);
  endtask

  task automatic handshake(input string tag);
    result_ready_i = 1'b1;
    step();
    result_ready_i = 1'b0;
    check({tag, "_valid_drop"}, result_valid_o, 1'b0);
    check({tag, "_busy_drop"}, busy_o, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_class"}, class_o, 0);
    check({tag, "_mode"}, stoch_log_o, 0);
    check({tag, "_inference"}, inference_o, 0);
    check({tag, "_rnd"}, rnd_o, 8'hE1);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_valid"}, result_valid_o, 0);
    check({tag, "_res_class"}, result_class_o, 0);
    check({tag, "_res_score"}, result_score_o, 0);
  endtask

  initial begin
    for (int c = 0; c < int'(N_CLASS); c++) begin
      thr[c]  = 0;
      dlog[c] = 0;
    end

    // 1: reset while idle
    #3 rst_ni = 1'b0;
    repeat (3) step();
    check_reset_outputs("t1_reset");
    rst_ni = 1'b1;
    step();
    step();
    check("t1_idle_busy", busy_o, 0);

    // 2: stochastic, only class 2 ever produces a 1
    thr = '{0, 0, 256, 0};
    foreach (dlog[c]) dlog[c] = $urandom_range(255, 0);
    model_stoch();
    run(1'b0, lat);
    check("t2_expected_class", exp_cls, 2);
    check("t2_expected_score", exp_score, 255);
    check_result("t2", lat);
    check("t2_mode_out", stoch_log_o, 0);
    handshake("t2");

    // 3: log domain with a tie between classes 1 and 2
    dlog = '{10, 40, 40, 5};
    model_log();
    run(1'b1, lat);
    check_result("t3", lat);
    check("t3_mode_out", stoch_log_o, 1);

    // 4: hold off ready, poke start meanwhile, then handshake with start
    for (int k = 0; k < 5; k++) begin
      start_i = (k == 2);
      step();
      check("t4_valid_hold", result_valid_o, 1);
      check("t4_busy_hold", busy_o, 1);
      check("t4_class_hold", result_class_o, 1);
      check("t4_score_hold", result_score_o, 40);
    end
    start_i = 1'b1;
    handshake("t4");
    start_i = 1'b0;
    step();
    check("t4_start_at_handshake_ignored", busy_o, 0);

    // 5: reset in the RUN phase of class 1, then a clean sweep
    foreach (thr[c]) thr[c] = $urandom_range(256, 0);
    mode_i  = 1'b0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    lat = 0;
    while (class_o != 2'd1 && lat < LIMIT) begin
      step();
      lat++;
    end
    check("t5_reached_class1", class_o, 1);
    repeat (SETTLE + 6) step();
    check("t5_in_run", inference_o, 1);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("t5_abort");
    step();
    rst_ni = 1'b1;
    step();
    foreach (thr[c]) thr[c] = $urandom_range(256, 0);
    model_stoch();
    run(1'b0, lat);
    check_result("t5", lat);
    handshake("t5");

    // 6: two back-to-back sweeps with an identical datapath model
    foreach (thr[c]) thr[c] = $urandom_range(256, 0);
    thr[3] = thr[1];  // force at least one candidate tie in the mix
    model_stoch();
    run(1'b0, lat_a);
    check_result("t6a", lat_a);
    first_q = rec_q;
    cls_a   = int'(result_class_o);
    score_a = int'(result_score_o);
    handshake("t6a");
    repeat (3) step();
    check("t6_rnd_frozen_idle", rnd_o, exp_final);
    run(1'b0, lat);
    check_result("t6b", lat);
    check("t6_same_latency", lat, lat_a);
    check("t6_same_class", result_class_o, cls_a);
    check("t6_same_score", result_score_o, score_a);
    check("t6_same_rnd_seq", (rec_q == first_q) ? 32'd1 : 32'd0, 1);
    handshake("t6b");

    // 1 again: reset while idle with the LFSR away from its seed
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("t1b_idle_reset");
    step();
    rst_ni = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_bayes_inference_seq
